regfl_wr_ctrl: RTL and testbench

REGFL_WR_CTRL -- requirements
Module: regfl_wr_ctrl

---
 rtl/regfl_wr_ctrl_pkg.sv | 15 +
 rtl/regfl_wr_ctrl_wr_fifo.sv | 52 +++++
 rtl/regfl_wr_ctrl.sv | 117 +++++++++++
 tb/tb_regfl_wr_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfl_wr_ctrl_pkg.sv
// Shared definitions for the register-file write controller: FSM states and
// default parameter values.
package regfl_wr_ctrl_pkg;

   localparam int unsigned DefAddrW = 3;
   localparam int unsigned DefRgstW = 64;
   localparam int unsigned DefDepth = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrain = 2'd1,
      StClear = 2'd2
   } state_e;

endpackage

// File: rtl/regfl_wr_ctrl_wr_fifo.sv
// Synchronous FIFO holding pending register writes; depth must be a power of 2.
// Pushes when full and pops when empty are dropped.
module wr_fifo
   import regfl_wr_ctrl_pkg::*;
#(
   parameter int unsigned width = DefAddrW + DefRgstW,
   parameter int unsigned depth = DefDepth,
   localparam int unsigned ptr_w = $clog2(depth),
   localparam int unsigned cnt_w = ptr_w + 1
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] wdata,
   output logic [width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [cnt_w-1:0] count
);

   logic [width-1:0] mem [depth];
   logic [ptr_w-1:0] wr_ptr_q, rd_ptr_q;
   logic [cnt_w-1:0] count_q;
   logic             push_ok, pop_ok;

   assign full    = (count_q == cnt_w'(depth));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + ptr_w'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + ptr_w'(1);
         if (push_ok && !pop_ok)      count_q <= count_q + cnt_w'(1);
         else if (!push_ok && pop_ok) count_q <= count_q - cnt_w'(1);
      end
   end

   // Storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/regfl_wr_ctrl.sv
// Register-file write controller: queues write requests and drives a single
// registered write port, with a drain-then-zero-fill clear sequence.
module regfl_wr_ctrl
   import regfl_wr_ctrl_pkg::*;
#(
   parameter int unsigned w      = DefAddrW,
   parameter int unsigned rgst_w = DefRgstW,
   parameter int unsigned depth  = DefDepth,
   localparam int unsigned cnt_w = $clog2(depth) + 1
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [w-1:0]      in_addr,
   input  logic [rgst_w-1:0] in_data,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              we,
   output logic [w-1:0]      s,
   output logic [rgst_w-1:0] d,
   output logic [cnt_w-1:0]  cnt
);

   localparam int unsigned ent_w = w + rgst_w;

   state_e            state_q, state_d;
   logic [w:0]        clr_cnt_q, clr_cnt_d, clr_cnt_inc;
   logic              clr_last, clr_issue, clr_tail_q;
   logic              push, pop, fifo_full, fifo_empty;
   logic [ent_w-1:0]  fifo_rdata;
   logic              we_q;
   logic [w-1:0]      s_q;
   logic [rgst_w-1:0] d_q;

   wr_fifo #(
      .width (ent_w),
      .depth (depth)
   ) u_wr_fifo (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (push),
      .pop   (pop),
      .wdata ({in_addr, in_data}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (cnt)
   );

   // Extra counter bit flags the terminal count without wrapping.
   assign clr_cnt_inc = clr_cnt_q + (w + 1)'(1);
   assign clr_last    = clr_cnt_inc[w];
   assign push        = in_vld && in_rdy;
   assign clr_busy    = (state_q != StIdle) || clr_tail_q;

   always_ff @(posedge clk) begin
      if (!rst_b) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         // An entry accepted alongside clr_req must drain before the zero-fill.
         StIdle:  if (clr_req) state_d = (!fifo_empty || push) ? StDrain : StClear;
         StDrain: if (cnt <= cnt_w'(1)) state_d = StClear;
         StClear: if (clr_last) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_rdy    = 1'b0;
      pop       = 1'b0;
      clr_issue = 1'b0;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         StIdle: begin
            in_rdy = !fifo_full;
            pop    = !fifo_empty;
         end
         StDrain: pop = !fifo_empty;
         StClear: begin
            clr_issue = 1'b1;
            clr_cnt_d = clr_last ? '0 : clr_cnt_inc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         clr_cnt_q  <= '0;
         clr_tail_q <= 1'b0;
         we_q       <= 1'b0;
         s_q        <= '0;
         d_q        <= '0;
      end else begin
         clr_cnt_q  <= clr_cnt_d;
         clr_tail_q <= clr_issue && clr_last;
         we_q       <= pop || clr_issue;
         if (pop) begin
            s_q <= fifo_rdata[ent_w-1:rgst_w];
            d_q <= fifo_rdata[rgst_w-1:0];
         end else if (clr_issue) begin
            s_q <= clr_cnt_q[w-1:0];
            d_q <= '0;
         end
      end
   end

   assign we = we_q;
   assign s  = s_q;
   assign d  = d_q;

endmodule

// File: tb/tb_regfl_wr_ctrl.sv
// Self-checking bench for regfl_wr_ctrl: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_regfl_wr_ctrl;

   localparam int unsigned W     = 3;
   localparam int unsigned RW    = 64;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NREG  = 8;
   localparam int unsigned CW    = 3;

   logic          clk = 1'b0;
   logic          rst_b, in_vld, clr_req;
   logic          in_rdy, clr_busy, we;
   logic [W-1:0]  in_addr, s;
   logic [RW-1:0] in_data, d;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   regfl_wr_ctrl #(
      .w      (W),
      .rgst_w (RW),
      .depth  (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .we       (we),
      .s        (s),
      .d        (d),
      .cnt      (cnt)
   );

   typedef struct packed {
      logic [W-1:0]  a;
      logic [RW-1:0] v;
   } ent_t;

   // Reference model: pending queue, mode (0 idle, 1 drain, 2 clear), expected port.
   ent_t          mq[$];
   int            m_mode = 0;
   int            m_idx  = 0;
   logic          m_we   = 1'b0;
   logic          m_tail = 1'b0;
   logic [W-1:0]  m_s    = '0;
   logic [RW-1:0] m_d    = '0;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      bit   acc;
      int   sz;
      ent_t e;
      if (!rst_b) begin
         mq.delete();
         m_mode = 0; m_idx = 0; m_we = 1'b0; m_tail = 1'b0; m_s = '0; m_d = '0;
         return;
      end
      sz     = mq.size();
      acc    = in_vld && (m_mode == 0) && (sz < DEPTH);
      m_tail = 1'b0;
      if (sz > 0 && m_mode != 2) begin
         m_we = 1'b1; m_s = mq[0].a; m_d = mq[0].v;
         void'(mq.pop_front());
      end else if (m_mode == 2) begin
         m_we = 1'b1; m_s = W'(m_idx); m_d = '0;
         m_tail = (m_idx == NREG - 1);
      end else begin
         m_we = 1'b0;
      end
      if (acc) begin
         e.a = in_addr; e.v = in_data;
         mq.push_back(e);
      end
      case (m_mode)
         0: if (clr_req) m_mode = (sz > 0 || acc) ? 1 : 2;
         1: if (mq.size() == 0) m_mode = 2;
         2: if (m_idx == NREG - 1) begin m_mode = 0; m_idx = 0; end else m_idx++;
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check("we", we, m_we);
      check("s", s, m_s);
      check("d", d, m_d);
      check("cnt", cnt, mq.size());
      check("in_rdy", in_rdy, (m_mode == 0) && (mq.size() < DEPTH));
      check("clr_busy", clr_busy, (m_mode != 0) || m_tail);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      bit found;
      rst_b = 1'b0; in_vld = 1'b0; clr_req = 1'b0; in_addr = '0; in_data = '0;
      step();
      step();
      rst_b = 1'b1;
      step();
      check("rdy_after_reset", in_rdy, 1'b1);

      // single write
      in_vld = 1'b1; in_addr = 3'd5; in_data = 64'hDEAD_BEEF;
      step();
      in_vld = 1'b0;
      step();
      check("single_we", we, 1'b1);
      check("single_s", s, 3'd5);
      check("single_d", d, 64'hDEAD_BEEF);
      step();
      check("single_we_off", we, 1'b0);

      // sustained requests
      for (int i = 0; i < 6; i++) begin
         in_vld = 1'b1; in_addr = W'($urandom); in_data = {$urandom, $urandom};
         step();
      end
      in_vld = 1'b0;
      repeat (3) step();

      // clear with a pending entry
      in_vld = 1'b1; in_addr = 3'd1; in_data = 64'h1234_5678_9ABC_DEF0;
      step();
      in_vld = 1'b0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      check("backlog_rdy_low", in_rdy, 1'b0);
      check("backlog_busy", clr_busy, 1'b1);
      repeat (14) step();

      // clear when empty
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      check("clr_empty_no_we_yet", we, 1'b0);
      check("clr_empty_busy", clr_busy, 1'b1);
      step();
      check("clr_first_we", we, 1'b1);
      check("clr_first_s", s, 3'd0);
      check("clr_first_d", d, 64'd0);
      repeat (7) step();
      check("clr_last_s", s, 3'd7);
      check("clr_last_busy", clr_busy, 1'b1);
      step();
      check("clr_done_busy", clr_busy, 1'b0);
      check("clr_done_we", we, 1'b0);

      // clr_req together with a push
      in_vld = 1'b1; in_addr = 3'd2; in_data = 64'hCAFE_F00D; clr_req = 1'b1;
      step();
      in_vld = 1'b0; clr_req = 1'b0;
      step();
      check("simul_push_we", we, 1'b1);
      check("simul_push_s", s, 3'd2);
      check("simul_push_d", d, 64'hCAFE_F00D);
      step();
      check("simul_zero_s", s, 3'd0);
      check("simul_zero_d", d, 64'd0);
      repeat (8) step();

      // reset while the clear writes address 3
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (we === 1'b1 && s === 3'd3) found = 1'b1;
      end
      check("found_clear_s3", found, 1'b1);
      rst_b = 1'b0;
      step();
      check("abort_we", we, 1'b0);
      check("abort_cnt", cnt, 3'd0);
      check("abort_busy", clr_busy, 1'b0);
      rst_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("abort_no_write", we, 1'b0);
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_vld  = ($urandom_range(0, 99) < 60);
         in_addr = W'($urandom);
         in_data = {$urandom, $urandom};
         clr_req = ($urandom_range(0, 99) < 5);
         rst_b   = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_b = 1'b1; in_vld = 1'b0; clr_req = 1'b0;
      repeat (12) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
